// File: rtl/reg_bank_dump_reader_if.sv
`default_nettype none
// =============================================================================
// Module   : reg_bank_dump_reader_if
// Purpose  : req/ack read port into the processor register bank.
// Revision : 1.0
// =============================================================================
interface reg_bank_dump_reader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;

  modport master (output rd_req, output rd_addr, input rd_ack, input rd_data);
  modport slave  (input rd_req, input rd_addr, output rd_ack, output rd_data);
endinterface
`default_nettype wire

// File: rtl/reg_bank_dump_reader.sv
`default_nettype none
// =============================================================================
// Module   : reg_bank_dump_reader
// Purpose  : Walks register addresses 0..NUM_REGS-1 over a req/ack port and
//            holds each value on the display outputs for DWELL_CYCLES.
//            Optional running checksum: define DUMP_CHECKSUM_EN.
// Revision : 1.0
// =============================================================================
module reg_bank_dump_reader #(
  parameter int ADDR_W       = 4,
  parameter int NUM_REGS     = 16,
  parameter int DATA_W       = 16,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int ACK_TIMEOUT  = 8
) (
  input  logic                   CLOCK_50,
  input  logic                   RESET_N,
  input  logic                   start_n,
  input  logic                   stop_n,
  input  logic                   cpu_wr,
  reg_bank_dump_reader_if.master rd,
  output logic [ADDR_W-1:0]      disp_addr,
  output logic [DATA_W-1:0]      disp_data,
  output logic                   disp_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [DATA_W-1:0]      checksum
);

  localparam int c_DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int c_TO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [c_DWELL_W-1:0] c_DWELL_LOAD = c_DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [c_DWELL_W-1:0] c_DWELL_ONE  = c_DWELL_W'(1);
  localparam logic [c_TO_W-1:0]    c_TO_LAST    = c_TO_W'(ACK_TIMEOUT - 1);
  localparam logic [c_TO_W-1:0]    c_TO_ONE     = c_TO_W'(1);
  localparam logic [ADDR_W-1:0]    c_LAST_ADDR  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0]    c_ADDR_ONE   = ADDR_W'(1);
  localparam logic [DATA_W-1:0]    c_ERR_DATA   = DATA_W'({((DATA_W + 3) / 4){4'hE}});

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_SHOW     = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t               r_state;
  logic [2:0]           r_start_sync;
  logic [2:0]           r_stop_sync;
  logic [c_DWELL_W-1:0] r_dwell;
  logic [c_TO_W-1:0]    r_to_cnt;
  logic                 r_rd_req;
  logic [ADDR_W-1:0]    r_rd_addr;
  logic [ADDR_W-1:0]    r_disp_addr;
  logic [DATA_W-1:0]    r_disp_data;
  logic                 r_disp_valid;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;

  logic w_start;
  logic w_stop;
  logic w_timeout;
  logic w_start_run;

  // Keys idle high; synchronizers reset to 1 so release never looks like a press.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_start_sync <= 3'b111;
      r_stop_sync  <= 3'b111;
    end else begin
      r_start_sync <= {r_start_sync[1:0], start_n};
      r_stop_sync  <= {r_stop_sync[1:0], stop_n};
    end
  end

  assign w_start     = r_start_sync[2] & ~r_start_sync[1];
  assign w_stop      = r_stop_sync[2] & ~r_stop_sync[1];
  assign w_timeout   = (r_to_cnt == c_TO_LAST);
  assign w_start_run = (r_state == S_IDLE) && w_start && !w_stop;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= S_IDLE;
      r_dwell      <= '0;
      r_to_cnt     <= '0;
      r_rd_req     <= 1'b0;
      r_rd_addr    <= '0;
      r_disp_addr  <= '0;
      r_disp_data  <= '0;
      r_disp_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_stop && (r_state != S_IDLE)) begin
        r_state  <= S_IDLE;
        r_rd_req <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start_run) begin
              r_rd_addr    <= '0;
              r_err        <= 1'b0;
              r_disp_valid <= 1'b0;
              r_busy       <= 1'b1;
              r_state      <= S_REQ;
            end
          end
          S_REQ: begin
            // Never launch a read while the processor writes the bank.
            if (!cpu_wr) begin
              r_rd_req <= 1'b1;
              r_to_cnt <= '0;
              r_state  <= S_WAIT_ACK;
            end
          end
          S_WAIT_ACK: begin
            if (rd.rd_ack || w_timeout) begin
              r_rd_req     <= 1'b0;
              r_disp_addr  <= r_rd_addr;
              r_disp_valid <= 1'b1;
              r_dwell      <= c_DWELL_LOAD;
              r_state      <= S_SHOW;
              if (rd.rd_ack) begin
                r_disp_data <= rd.rd_data;
              end else begin
                r_disp_data <= c_ERR_DATA;
                r_err       <= 1'b1;
              end
            end else begin
              r_to_cnt <= r_to_cnt + c_TO_ONE;
            end
          end
          S_SHOW: begin
            if (r_dwell == '0) begin
              if (r_rd_addr == c_LAST_ADDR) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_rd_addr <= r_rd_addr + c_ADDR_ONE;
                r_state   <= S_REQ;
              end
            end else begin
              r_dwell <= r_dwell - c_DWELL_ONE;
            end
          end
          S_DONE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_rd_req <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end
        endcase
      end
    end
  end

`ifdef DUMP_CHECKSUM_EN
  logic              w_cap;
  logic [DATA_W-1:0] w_cap_val;
  logic [DATA_W-1:0] r_checksum;

  // Accumulates exactly what lands on disp_data, including the timeout filler.
  assign w_cap     = (r_state == S_WAIT_ACK) && !w_stop && (rd.rd_ack || w_timeout);
  assign w_cap_val = rd.rd_ack ? rd.rd_data : c_ERR_DATA;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_checksum <= '0;
    end else if (w_start_run) begin
      r_checksum <= '0;
    end else if (w_cap) begin
      r_checksum <= r_checksum + w_cap_val;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign rd.rd_req  = r_rd_req;
  assign rd.rd_addr = r_rd_addr;
  assign disp_addr  = r_disp_addr;
  assign disp_data  = r_disp_data;
  assign disp_valid = r_disp_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_dump_reader.sv
`default_nettype none
// =============================================================================
// Module   : tb_reg_bank_dump_reader
// Purpose  : Scoreboard bench for reg_bank_dump_reader (4 regs, dwell 3, timeout 8).
// Revision : 1.0
// =============================================================================
module tb_reg_bank_dump_reader;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N;
  logic        start_n;
  logic        stop_n;
  logic        cpu_wr;
  logic [3:0]  disp_addr;
  logic [15:0] disp_data;
  logic        disp_valid;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] checksum;

  reg_bank_dump_reader_if #(.ADDR_W(4), .DATA_W(16)) rd_if ();

  reg_bank_dump_reader #(
    .ADDR_W(4), .NUM_REGS(4), .DATA_W(16), .DWELL_CYCLES(3), .ACK_TIMEOUT(8)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET_N   (RESET_N),
    .start_n   (start_n),
    .stop_n    (stop_n),
    .cpu_wr    (cpu_wr),
    .rd        (rd_if),
    .disp_addr (disp_addr),
    .disp_data (disp_data),
    .disp_valid(disp_valid),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .checksum  (checksum)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    bit          is_done;
    logic [3:0]  addr;
    logic [15:0] data;
    logic        err;
    logic [15:0] cks;
    int          hi;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] mem [0:3];
  int          no_ack_addr = -1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] cks(input logic [15:0] v);
`ifdef DUMP_CHECKSUM_EN
    return v;
`else
    return v & 16'h0000;
`endif
  endfunction

  task automatic push_disp(input logic [3:0] a, input logic [15:0] d, input logic e, input int hi);
    exp_t x;
    x.is_done = 1'b0; x.addr = a; x.data = d; x.err = e; x.cks = '0; x.hi = hi;
    sb.push_back(x);
  endtask

  task automatic push_done(input logic e, input logic [15:0] c);
    exp_t x;
    x.is_done = 1'b1; x.addr = '0; x.data = '0; x.err = e; x.cks = c; x.hi = 0;
    sb.push_back(x);
  endtask

  // Normal 4-register run with the current mem contents and 1-cycle acks.
  task automatic push_run(input logic [15:0] sum);
    for (int i = 0; i < 4; i++) push_disp(4'(i), mem[i], 1'b0, 1);
    push_done(1'b0, cks(sum));
  endtask

  task automatic do_start();
    start_n = 1'b0;
    for (int n = 0; n < 20 && !busy; n++) @(negedge CLOCK_50);
    check("start_busy_rise", {31'd0, busy}, 32'd1);
    start_n = 1'b1;
  endtask

  task automatic do_stop();
    stop_n = 1'b0;
    for (int n = 0; n < 20 && busy; n++) @(negedge CLOCK_50);
    check("stop_busy_fall", {31'd0, busy}, 32'd0);
    stop_n = 1'b1;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 500 && busy; n++) @(negedge CLOCK_50);
    check("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  // Read-port responder: acks one cycle after rd_req unless the address is blocked.
  always @(negedge CLOCK_50) begin
    if (rd_if.rd_req && (int'(rd_if.rd_addr) != no_ack_addr)) begin
      rd_if.rd_ack  = 1'b1;
      rd_if.rd_data = mem[rd_if.rd_addr[1:0]];
    end else begin
      rd_if.rd_ack  = 1'b0;
      rd_if.rd_data = 16'hDEAD;
    end
  end

  // Monitor: a falling rd_req marks a capture; done marks run completion.
  logic prev_req = 1'b0;
  int   hi_cnt   = 0;
  always @(negedge CLOCK_50) begin
    exp_t e;
    if (!RESET_N) begin
      prev_req = 1'b0;
      hi_cnt   = 0;
    end else begin
      if (rd_if.rd_req) hi_cnt++;
      if (prev_req && !rd_if.rd_req) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected_capture actual addr=%h data=%h required none", disp_addr, disp_data);
        end else begin
          e = sb.pop_front();
          check("cap_kind", {31'd0, e.is_done}, 32'd0);
          check("cap_disp_addr", {28'd0, disp_addr}, {28'd0, e.addr});
          check("cap_disp_data", {16'd0, disp_data}, {16'd0, e.data});
          check("cap_err", {31'd0, err}, {31'd0, e.err});
          check("cap_disp_valid", {31'd0, disp_valid}, 32'd1);
          check("cap_req_cycles", hi_cnt, e.hi);
        end
      end
      if (!rd_if.rd_req) hi_cnt = 0;
      if (done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected_done actual done=1 required none");
        end else begin
          e = sb.pop_front();
          check("done_kind", {31'd0, e.is_done}, 32'd1);
          check("done_err", {31'd0, err}, {31'd0, e.err});
          check("done_checksum", {16'd0, checksum}, {16'd0, e.cks});
          check("done_busy", {31'd0, busy}, 32'd1);
        end
      end
      prev_req = rd_if.rd_req;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0; start_n = 1'b1; stop_n = 1'b1; cpu_wr = 1'b0;
    rd_if.rd_ack = 1'b0; rd_if.rd_data = '0;
    for (int i = 0; i < 4; i++) mem[i] = 16'(i * 16'h1111);
    repeat (3) @(negedge CLOCK_50);
    check("rst_rd_req", {31'd0, rd_if.rd_req}, 32'd0);
    check("rst_rd_addr", {28'd0, rd_if.rd_addr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_disp_valid", {31'd0, disp_valid}, 32'd0);
    check("rst_disp_data", {16'd0, disp_data}, 32'd0);
    check("rst_checksum", {16'd0, checksum}, 32'd0);
    RESET_N = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    // Basic run: 0000,1111,2222,3333
    push_run(16'h6666);
    do_start();
    wait_idle();
    check("t1_disp_addr", {28'd0, disp_addr}, 32'd3);
    check("t1_disp_data", {16'd0, disp_data}, 32'h3333);
    check("t1_disp_valid", {31'd0, disp_valid}, 32'd1);
    check("t1_done_low", {31'd0, done}, 32'd0);

    // cpu_wr blocks the read for 5 REQ cycles
    cpu_wr = 1'b1;
    push_run(16'h6666);
    do_start();
    for (int i = 0; i < 5; i++) begin
      check("t2_req_blocked", {31'd0, rd_if.rd_req}, 32'd0);
      check("t2_addr_hold", {28'd0, rd_if.rd_addr}, 32'd0);
      if (i < 4) @(negedge CLOCK_50);
    end
    cpu_wr = 1'b0;
    @(negedge CLOCK_50);
    check("t2_req_after_wr", {31'd0, rd_if.rd_req}, 32'd1);
    check("t2_addr_after_wr", {28'd0, rd_if.rd_addr}, 32'd0);
    wait_idle();

    // Timeout on addr 2: 0+1111+EEEE+3333 = 3332 mod 2^16
    no_ack_addr = 2;
    push_disp(4'd0, 16'h0000, 1'b0, 1);
    push_disp(4'd1, 16'h1111, 1'b0, 1);
    push_disp(4'd2, 16'hEEEE, 1'b1, 8);
    push_disp(4'd3, 16'h3333, 1'b1, 1);
    push_done(1'b1, cks(16'h3332));
    do_start();
    wait_idle();
    check("t3_err_sticky", {31'd0, err}, 32'd1);
    no_ack_addr = -1;

    // Stop during SHOW of addr 1
    push_disp(4'd0, 16'h0000, 1'b0, 1);
    push_disp(4'd1, 16'h1111, 1'b0, 1);
    do_start();
    for (int n = 0; n < 100 && !(disp_valid && disp_addr == 4'd1 && !rd_if.rd_req); n++)
      @(negedge CLOCK_50);
    check("t4_in_show1", {28'd0, disp_addr}, 32'd1);
    do_stop();
    repeat (10) @(negedge CLOCK_50);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_disp_data", {16'd0, disp_data}, 32'h1111);
    check("t4_disp_addr", {28'd0, disp_addr}, 32'd1);
    check("t4_err", {31'd0, err}, 32'd0);
    check("t4_rd_req", {31'd0, rd_if.rd_req}, 32'd0);

    // Reset while waiting for an ack on addr 1
    no_ack_addr = 1;
    push_disp(4'd0, 16'h0000, 1'b0, 1);
    do_start();
    for (int n = 0; n < 100 && !(rd_if.rd_req && rd_if.rd_addr == 4'd1); n++)
      @(negedge CLOCK_50);
    check("t5_in_wait1", {31'd0, rd_if.rd_req}, 32'd1);
    RESET_N = 1'b0;
    #1;
    check("t5_rst_rd_req", {31'd0, rd_if.rd_req}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_disp_valid", {31'd0, disp_valid}, 32'd0);
    check("t5_rst_disp_data", {16'd0, disp_data}, 32'd0);
    check("t5_rst_disp_addr", {28'd0, disp_addr}, 32'd0);
    check("t5_rst_checksum", {16'd0, checksum}, 32'd0);
    repeat (2) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    no_ack_addr = -1;
    @(negedge CLOCK_50);
    push_run(16'h6666);
    do_start();
    check("t5_restart_addr", {28'd0, rd_if.rd_addr}, 32'd0);
    wait_idle();
    check("t5_final_addr", {28'd0, disp_addr}, 32'd3);

    // Checksum wraps: 1+2+3+FFFF = 0005
    mem[0] = 16'h0001; mem[1] = 16'h0002; mem[2] = 16'h0003; mem[3] = 16'hFFFF;
    push_run(16'h0005);
    do_start();
    wait_idle();
    check("t6_checksum_hold", {16'd0, checksum}, {16'd0, cks(16'h0005)});

    repeat (5) @(negedge CLOCK_50);
    check("sb_drain", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
